// File: rtl/pattern_scan_arbiter.sv
// Purpose: round-robin arbiter that grants one of four byte channels to a shared "bomb" pattern matcher.
// Latency: grant one edge after a request in IDLE; found_pattern one edge after the completing byte.
// Backpressure: ready follows valid of the granted channel in SCAN only; a report stalls the owner until ack.
module pattern_scan_arbiter #(
    parameter logic [31:0] PATTERN  = 32'h626F6D62,
    parameter int unsigned MAX_IDLE = 8
) (
    input  logic        clk,
    input  logic        reset_sync,
    input  logic [3:0]  req,
    input  logic [3:0]  valid,
    input  logic [31:0] data,
    input  logic        ack,
    output logic [3:0]  grant,
    output logic        ready,
    output logic        found_pattern,
    output logic [1:0]  match_chan,
    output logic        timeout,
    output logic [15:0] match_count
);

    typedef enum logic [1:0] {IDLE, SCAN, REPORT} state_t;

    localparam logic [7:0] MAX_IDLE_C = 8'(MAX_IDLE);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_grant;
    logic [1:0]  r_owner;
    logic [1:0]  r_last_owner;
    logic [31:0] r_shift;
    logic [7:0]  r_idle_cnt;
    logic        r_found;
    logic [1:0]  r_match_chan;
    logic        r_timeout;
    logic [15:0] r_match_count;

    logic [7:0]  w_byte;
    logic [31:0] w_shift_nxt;
    logic        w_vld_g;
    logic        w_req_g;
    logic        w_accept;
    logic        w_match;
    logic        w_idle_hit;
    logic [1:0]  w_pick;
    logic        w_load;
    logic        w_release;
    logic        w_report;
    logic        w_done;

    // Only the owner's lane is visible to the matcher; other channels are ignored here.
    assign w_vld_g     = valid[r_owner];
    assign w_req_g     = req[r_owner];
    assign w_byte      = data[8*r_owner +: 8];
    assign w_accept    = (r_state == SCAN) && w_vld_g;
    assign w_shift_nxt = {r_shift[23:0], w_byte};
    assign w_match     = w_accept && (w_shift_nxt == PATTERN);
    assign w_idle_hit  = (r_state == SCAN) && !w_vld_g && ((r_idle_cnt + 8'd1) == MAX_IDLE_C);

    // Round-robin pick: scan from the farthest candidate to the nearest so the channel right after last_owner wins.
    always_comb begin
        w_pick = r_last_owner;
        for (int k = 4; k >= 1; k--) begin
            if (req[r_last_owner + 2'(k)]) begin
                w_pick = r_last_owner + 2'(k);
            end
        end
    end

    // Next-state decode; a completing match outranks both req drop and idle release.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_release   = 1'b0;
        w_report    = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            IDLE: begin
                if (|req) begin
                    w_load      = 1'b1;
                    w_state_nxt = SCAN;
                end
            end
            SCAN: begin
                if (w_match) begin
                    w_report    = 1'b1;
                    w_state_nxt = REPORT;
                end else if (w_idle_hit || !w_req_g) begin
                    w_release   = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            REPORT: begin
                if (ack) begin
                    w_done      = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_sync) begin
        if (!reset_sync) r_state <= IDLE;
        else             r_state <= w_state_nxt;
    end

    // Grant, ownership, shift register, idle counter and report registers.
    always_ff @(posedge clk or negedge reset_sync) begin
        if (!reset_sync) begin
            r_grant       <= 4'd0;
            r_owner       <= 2'd0;
            r_last_owner  <= 2'd3;
            r_shift       <= 32'd0;
            r_idle_cnt    <= 8'd0;
            r_found       <= 1'b0;
            r_match_chan  <= 2'd0;
            r_timeout     <= 1'b0;
            r_match_count <= 16'd0;
        end else begin
            r_timeout <= w_release && w_idle_hit;
            if (w_load) begin
                r_grant    <= 4'b0001 << w_pick;
                r_owner    <= w_pick;
                r_shift    <= 32'd0;
                r_idle_cnt <= 8'd0;
            end else if (r_state == SCAN) begin
                if (w_accept) begin
                    r_shift    <= w_shift_nxt;
                    r_idle_cnt <= 8'd0;
                end else begin
                    r_idle_cnt <= r_idle_cnt + 8'd1;
                end
            end
            if (w_release || w_done) begin
                r_grant      <= 4'd0;
                r_last_owner <= r_owner;
            end
            if (w_report) begin
                r_found      <= 1'b1;
                r_match_chan <= r_owner;
                if (r_match_count != 16'hFFFF) r_match_count <= r_match_count + 16'd1;
            end else if (w_done) begin
                r_found <= 1'b0;
            end
        end
    end

    assign grant         = r_grant;
    assign ready         = w_accept;
    assign found_pattern = r_found;
    assign match_chan    = r_match_chan;
    assign timeout       = r_timeout;
    assign match_count   = r_match_count;

endmodule

// File: tb/tb_pattern_scan_arbiter.sv
// Purpose: randomized and directed bench for pattern_scan_arbiter with a queue-based scoreboard.
// Latency: inputs change on the falling edge, registered outputs are sampled 2ns after the rising edge.
// Backpressure: ack is driven randomly; the reference model decides when bytes are consumed.
module tb_pattern_scan_arbiter;

    localparam logic [31:0] PAT  = 32'h626F6D62;
    localparam int          MAXI = 8;

    logic        clk = 1'b0;
    logic        reset_sync;
    logic [3:0]  req;
    logic [3:0]  valid;
    logic [31:0] data;
    logic        ack;
    logic [3:0]  grant;
    logic        ready;
    logic        found_pattern;
    logic [1:0]  match_chan;
    logic        timeout;
    logic [15:0] match_count;

    pattern_scan_arbiter #(.PATTERN(PAT), .MAX_IDLE(MAXI)) dut (
        .clk(clk), .reset_sync(reset_sync), .req(req), .valid(valid), .data(data), .ack(ack),
        .grant(grant), .ready(ready), .found_pattern(found_pattern), .match_chan(match_chan),
        .timeout(timeout), .match_count(match_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]  chan;
        logic [15:0] cnt;
    } match_t;

    match_t     match_q[$];
    logic [3:0] grant_q[$];
    logic [3:0] tmo_q[$];

    // Reference model: mode 0 = no owner, 1 = owner streaming bytes, 2 = match awaiting ack.
    int         m_mode;
    int         m_owner;
    int         m_last;
    int         m_idle;
    int         m_count;
    logic [7:0] m_hist[$];
    logic [7:0] pat_b[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_owner = 0; m_last = 3; m_idle = 0; m_count = 0;
        m_hist.delete();
    endtask

    function automatic logic [31:0] onch(input int ch, input logic [7:0] b);
        return 32'(b) << (8 * ch);
    endfunction

    task automatic model_step(input logic [3:0] rq, input logic [3:0] vl, input logic [31:0] dt, input logic ak);
        bit hit;
        hit = 0;
        case (m_mode)
            0: if (rq != 4'd0) begin
                for (int k = 4; k >= 1; k--) if (rq[(m_last + k) % 4]) m_owner = (m_last + k) % 4;
                m_hist.delete();
                m_idle = 0;
                m_mode = 1;
                grant_q.push_back(4'b0001 << m_owner);
            end
            1: begin
                if (vl[m_owner]) begin
                    m_hist.push_back(dt[8*m_owner +: 8]);
                    if (m_hist.size() > 4) void'(m_hist.pop_front());
                    m_idle = 0;
                    if (m_hist.size() == 4) begin
                        hit = 1;
                        for (int i = 0; i < 4; i++) if (m_hist[i] != pat_b[i]) hit = 0;
                    end
                end else begin
                    m_idle++;
                end
                if (hit) begin
                    if (m_count < 65535) m_count++;
                    match_q.push_back('{chan: 2'(m_owner), cnt: 16'(m_count)});
                    m_mode = 2;
                end else if (m_idle == MAXI) begin
                    tmo_q.push_back(4'b0001 << m_owner);
                    m_last = m_owner;
                    m_mode = 0;
                end else if (!rq[m_owner]) begin
                    m_last = m_owner;
                    m_mode = 0;
                end
            end
            default: if (ak) begin
                m_last = m_owner;
                m_mode = 0;
            end
        endcase
    endtask

    // One stimulus cycle: drive, check combinational/level outputs against the model, then advance the model.
    task automatic cyc(input logic [3:0] rq, input logic [3:0] vl, input logic [31:0] dt, input logic ak);
        @(negedge clk);
        req = rq; valid = vl; data = dt; ack = ak;
        #1;
        check("ready", ready, (m_mode == 1) && vl[m_owner]);
        check("grant", grant, (m_mode != 0) ? (4'b0001 << m_owner) : 4'd0);
        check("found_level", found_pattern, m_mode == 2);
        model_step(rq, vl, dt, ak);
    endtask

    task automatic feed(input int ch, input logic [3:0] rq, input logic [7:0] b);
        cyc(rq, 4'b0001 << ch, onch(ch, b), 1'b0);
    endtask

    task automatic do_reset_async();
        @(negedge clk);
        #2;
        reset_sync = 1'b0;
        #1;
        check("rst_found", found_pattern, 0);
        check("rst_grant", grant, 0);
        check("rst_count", match_count, 0);
        check("rst_timeout", timeout, 0);
        check("rst_chan", match_chan, 0);
        match_q.delete(); grant_q.delete(); tmo_q.delete();
        model_reset();
        req = 4'd0; valid = 4'd0; ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_sync = 1'b1;
    endtask

    // Monitor: pops expected events whenever the DUT reports a match, a timeout, or a fresh grant.
    initial begin
        logic [3:0] pg;
        logic       pf;
        match_t     e;
        logic [3:0] eg;
        pg = 4'd0; pf = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (reset_sync) begin
                if (found_pattern && !pf) begin
                    if (match_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL sb_match: unexpected report chan %0d count %0d, none required", match_chan, match_count);
                    end else begin
                        e = match_q.pop_front();
                        check("sb_match_chan", match_chan, e.chan);
                        check("sb_match_count", match_count, e.cnt);
                    end
                end
                if (timeout) begin
                    if (tmo_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL sb_timeout: unexpected timeout pulse, none required");
                    end else begin
                        eg = tmo_q.pop_front();
                        check("sb_timeout_owner", pg, eg);
                        check("sb_timeout_grant_clear", grant, 0);
                    end
                end
                if (grant != 4'd0 && pg == 4'd0) begin
                    if (grant_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL sb_grant: unexpected grant %b, none required", grant);
                    end else begin
                        eg = grant_q.pop_front();
                        check("sb_grant", grant, eg);
                    end
                end
            end
            pg = grant;
            pf = found_pattern;
        end
    end

    // Stimulus: directed scenarios followed by randomized traffic.
    initial begin
        logic [31:0] pat_v;
        logic [3:0]  rq_r;
        logic [3:0]  vl;
        logic [31:0] dt;
        logic [7:0]  b;
        int          vp;

        reset_sync = 1'b0; req = 4'd0; valid = 4'd0; data = 32'd0; ack = 1'b0;
        pat_v = PAT;
        for (int i = 0; i < 4; i++) pat_b[i] = pat_v[31 - 8*i -: 8];
        model_reset();
        repeat (3) @(negedge clk);
        check("reset_grant", grant, 0);
        check("reset_found", found_pattern, 0);
        check("reset_count", match_count, 0);
        check("reset_timeout", timeout, 0);
        check("reset_ready", ready, 0);
        reset_sync = 1'b1;

        // Channel 0 wins first, channel 2 after it releases.
        cyc(4'b0101, 4'd0, 32'd0, 1'b0);
        cyc(4'b0101, 4'd0, 32'd0, 1'b0);
        cyc(4'b0100, 4'd0, 32'd0, 1'b0);
        cyc(4'b0100, 4'd0, 32'd0, 1'b0);
        cyc(4'b0100, 4'd0, 32'd0, 1'b0);
        cyc(4'b0000, 4'd0, 32'd0, 1'b0);

        // Channel 1 match, held report, then ack.
        cyc(4'b0010, 4'd0, 32'd0, 1'b0);
        feed(1, 4'b0010, 8'h62); feed(1, 4'b0010, 8'h6F); feed(1, 4'b0010, 8'h6D); feed(1, 4'b0010, 8'h62);
        cyc(4'b0010, 4'b0010, onch(1, 8'h62), 1'b0);
        cyc(4'b0010, 4'b0010, onch(1, 8'h62), 1'b1);

        // Re-grant clears history: trailing 6F,6D,62 must not match.
        cyc(4'b0010, 4'd0, 32'd0, 1'b0);
        feed(1, 4'b0010, 8'h6F); feed(1, 4'b0010, 8'h6D); feed(1, 4'b0010, 8'h62);
        feed(1, 4'b0010, 8'h62); feed(1, 4'b0010, 8'h6F); feed(1, 4'b0010, 8'h6D); feed(1, 4'b0010, 8'h62);
        cyc(4'b0000, 4'd0, 32'd0, 1'b1);

        // Idle timeout on channel 2, channel 3 granted next.
        cyc(4'b0100, 4'd0, 32'd0, 1'b0);
        repeat (MAXI) cyc(4'b1100, 4'd0, 32'd0, 1'b0);
        cyc(4'b1100, 4'd0, 32'd0, 1'b0);
        cyc(4'b1000, 4'd0, 32'd0, 1'b0);

        // Channel 3 drops req on the completing byte: match still wins.
        feed(3, 4'b1000, 8'h62); feed(3, 4'b1000, 8'h6F); feed(3, 4'b1000, 8'h6D);
        cyc(4'b0000, 4'b1000, onch(3, 8'h62), 1'b0);
        cyc(4'b0000, 4'd0, 32'd0, 1'b0);

        // Asynchronous reset while a report is pending.
        @(negedge clk);
        check("pre_reset_found", found_pattern, 1);
        do_reset_async();

        // Randomized traffic with alternating valid density.
        rq_r = 4'd0;
        for (int n = 0; n < 3000; n++) begin
            for (int c = 0; c < 4; c++) if ($urandom_range(0, 9) == 0) rq_r[c] = ~rq_r[c];
            vp = ((n / 500) % 2 == 1) ? 25 : 85;
            for (int c = 0; c < 4; c++) begin
                vl[c] = ($urandom_range(0, 99) < vp);
                case ($urandom_range(0, 3))
                    0: b = 8'h62;
                    1: b = 8'h6F;
                    2: b = 8'h6D;
                    default: b = 8'($urandom_range(0, 255));
                endcase
                dt[8*c +: 8] = b;
            end
            cyc(rq_r, vl, dt, $urandom_range(0, 3) == 0);
        end

        // Drain: drop requests and acknowledge anything pending.
        repeat (4) cyc(4'd0, 4'd0, 32'd0, 1'b1);
        @(negedge clk);
        check("final_count", match_count, m_count);
        check("match_q_empty", match_q.size(), 0);
        check("grant_q_empty", grant_q.size(), 0);
        check("tmo_q_empty", tmo_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
